// File: rtl/mem_arbiter.sv
// Two-requester (I-cache / D-cache) arbiter driving a single AXI4-Lite master port.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise the data cache has fixed priority.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_ack,
    output logic [DATA_W-1:0]     i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wstrb,
    output logic                  d_ack,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  err,
    output logic [ADDR_W-1:0]     awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic [ADDR_W-1:0]     araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_ADDR = 3'd1;
    localparam logic [2:0] ST_RD_DATA = 3'd2;
    localparam logic [2:0] ST_WR_REQ  = 3'd3;
    localparam logic [2:0] ST_WR_RESP = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    logic [2:0]          state_r;
    logic                gnt_d_r;
    logic                we_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [DATA_W/8-1:0] wstrb_r;
    logic                arvalid_r, rready_r, awvalid_r, wvalid_r, bready_r;
    logic                i_ack_r, d_ack_r, err_r;
    logic [DATA_W-1:0]   i_rdata_r, d_rdata_r;
    logic                prev_i_ack_r, prev_d_ack_r;
`ifdef MEM_ARB_RR_EN
    logic                prio_i_r;
`endif

    logic req_i_s, req_d_s, pick_d_s, start_s;
    logic aw_pend_s, w_pend_s;

    // Request masking, grant selection and write-channel handshake bookkeeping
    always_comb begin
        // a requester acked last cycle may still be holding req; ignore it once
        req_i_s = i_req && !prev_i_ack_r;
        req_d_s = d_req && !prev_d_ack_r;
`ifdef MEM_ARB_RR_EN
        if (req_i_s && req_d_s) begin
            pick_d_s = !prio_i_r;
        end else begin
            pick_d_s = req_d_s;
        end
`else
        pick_d_s = req_d_s;
`endif
        start_s   = req_i_s || req_d_s;
        aw_pend_s = awvalid_r && !awready;
        w_pend_s  = wvalid_r && !wready;
    end

    // Transaction sequencer; every output is a register updated here
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            gnt_d_r      <= 1'b0;
            we_r         <= 1'b0;
            addr_r       <= {ADDR_W{1'b0}};
            wdata_r      <= {DATA_W{1'b0}};
            wstrb_r      <= {(DATA_W/8){1'b0}};
            arvalid_r    <= 1'b0;
            rready_r     <= 1'b0;
            awvalid_r    <= 1'b0;
            wvalid_r     <= 1'b0;
            bready_r     <= 1'b0;
            i_ack_r      <= 1'b0;
            d_ack_r      <= 1'b0;
            err_r        <= 1'b0;
            i_rdata_r    <= {DATA_W{1'b0}};
            d_rdata_r    <= {DATA_W{1'b0}};
            prev_i_ack_r <= 1'b0;
            prev_d_ack_r <= 1'b0;
`ifdef MEM_ARB_RR_EN
            prio_i_r     <= 1'b1;
`endif
        end else begin
            prev_i_ack_r <= i_ack_r;
            prev_d_ack_r <= d_ack_r;
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        gnt_d_r <= pick_d_s;
                        if (pick_d_s) begin
                            addr_r  <= d_addr;
                            we_r    <= d_we;
                            wdata_r <= d_wdata;
                            wstrb_r <= d_wstrb;
                        end else begin
                            addr_r  <= i_addr;
                            we_r    <= 1'b0;
                            wdata_r <= {DATA_W{1'b0}};
                            wstrb_r <= {(DATA_W/8){1'b0}};
                        end
                        if (pick_d_s && d_we) begin
                            awvalid_r <= 1'b1;
                            wvalid_r  <= 1'b1;
                            state_r   <= ST_WR_REQ;
                        end else begin
                            arvalid_r <= 1'b1;
                            state_r   <= ST_RD_ADDR;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RD_ADDR: begin
                    if (arvalid_r && arready) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state_r   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (rvalid) begin
                        rready_r <= 1'b0;
                        err_r    <= (rresp != 2'b00);
                        if (gnt_d_r) begin
                            d_rdata_r <= rdata;
                            d_ack_r   <= 1'b1;
                        end else begin
                            i_rdata_r <= rdata;
                            i_ack_r   <= 1'b1;
                        end
                        state_r <= ST_DONE;
                    end
                end
                ST_WR_REQ: begin
                    // AW and W complete independently; leave once neither is outstanding
                    awvalid_r <= aw_pend_s;
                    wvalid_r  <= w_pend_s;
                    if (!aw_pend_s && !w_pend_s) begin
                        bready_r <= 1'b1;
                        state_r  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (bvalid) begin
                        bready_r  <= 1'b0;
                        err_r     <= (bresp != 2'b00);
                        d_rdata_r <= {DATA_W{1'b0}};
                        d_ack_r   <= 1'b1;
                        state_r   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    i_ack_r   <= 1'b0;
                    d_ack_r   <= 1'b0;
                    err_r     <= 1'b0;
                    i_rdata_r <= {DATA_W{1'b0}};
                    d_rdata_r <= {DATA_W{1'b0}};
`ifdef MEM_ARB_RR_EN
                    prio_i_r  <= gnt_d_r;
`endif
                    state_r   <= ST_IDLE;
                end
                default: begin
                    arvalid_r <= 1'b0;
                    rready_r  <= 1'b0;
                    awvalid_r <= 1'b0;
                    wvalid_r  <= 1'b0;
                    bready_r  <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign i_ack   = i_ack_r;
    assign d_ack   = d_ack_r;
    assign i_rdata = i_rdata_r;
    assign d_rdata = d_rdata_r;
    assign err     = err_r;
    assign araddr  = addr_r;
    assign awaddr  = addr_r;
    assign wdata   = wdata_r;
    assign wstrb   = wstrb_r;
    assign arvalid = arvalid_r;
    assign rready  = rready_r;
    assign awvalid = awvalid_r;
    assign wvalid  = wvalid_r;
    assign bready  = bready_r;

endmodule
